io_poll_master: RTL
===================

IO_POLL_MASTER -- requirements
Module: io_poll_master

Interface
REQ-001 Parameter POLL_DIV, default 100000, is the number of clk_i cycles between poll starts; it SHALL be at least 8.
REQ-002 Parameter DEBOUNCE_N, default 4, is the number of consecutive identical button samples needed to accept a new level; it SHALL be between 2 and 8.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 enable_i  input  1  poll enable.
REQ-006 dram_addr_o  output  32  bus address to the IO responder.
REQ-007 dram_we_o  output  1  bus write strobe, one cycle per write.
REQ-008 dram_wdata_o  output  32  bus write data.
REQ-009 dram_rdata_i  input  32  bus read data; combinational from the responder for the same-cycle address.
REQ-010 busy_o  output  1  high when the FSM is not in IDLE.
REQ-011 press_o  output  1  one-cycle pulse on an accepted press event.
REQ-012 btn_db_o  output  5  debounced button levels.
REQ-013 press_cnt_o  output  32  accepted press count.

Function
REQ-014 Tick counter: while enable_i=1, increments 0..POLL_DIV-1 and wraps; a tick occurs on the wrap cycle; while enable_i=0, the counter holds at 0.
REQ-015 FSM states: IDLE, RD_SW, RD_BTN, WR_LED, WR_DIG, each lasting exactly 1 cycle.
REQ-016 Transition IDLE->RD_SW on the cycle after a tick; a tick while not in IDLE is dropped.
REQ-017 RD_SW drives addr=SWITCH_ADDR, we=0; captures sw_q <= dram_rdata_i[23:0] at the cycle end.
REQ-018 RD_BTN drives addr=BUTTON_ADDR, we=0; shifts dram_rdata_i[4:0] into the debouncer at the cycle end.
REQ-019 Debouncer, per bit: btn_db updates to the sampled level only when the last DEBOUNCE_N samples are equal; samples are taken only in RD_BTN.
REQ-020 Press event: any bit of btn_db rises 0->1 on an RD_BTN update; simultaneous rises on several bits count as one event.
REQ-021 WR_LED drives addr=LED_ADDR, we=1, wdata={8'h00, sw_q}; it is always executed.
REQ-022 After WR_LED, the FSM goes to WR_DIG if a press event occurred this poll, else to IDLE.
REQ-023 WR_DIG drives addr=DIGIT_ADDR, we=1, wdata=press_cnt+1; in the same cycle press_cnt increments (wrapping 0xFFFF_FFFF->0) and press_o=1.
REQ-024 In IDLE, and in any non-write state, dram_we_o SHALL be 0; in IDLE, addr=0 and wdata=0.
REQ-025 Deasserting enable_i mid-sequence SHALL NOT abort the sequence; the sequence completes, then the FSM remains in IDLE.
REQ-026 Poll latency: the WR_LED strobe occurs 3 cycles after the tick cycle; the WR_DIG strobe, when present, occurs 4 cycles after.

Reset
REQ-027 On rst_i=1 at a clock edge, the following are cleared next cycle: FSM=IDLE, tick counter=0, sw_q=0, debouncer history=0, btn_db_o=0, press_cnt_o=0, press_o=0, busy_o=0, and bus outputs 0.
REQ-028 Reset asserted mid-sequence SHALL suppress any pending write; no we=1 appears in the cycle following reset.

Structure
REQ-029 Shared package io_map_pkg holds SWITCH_ADDR=0xFFFF_F070, BUTTON_ADDR=0xFFFF_F078, LED_ADDR=0xFFFF_F060, DIGIT_ADDR=0xFFFF_F000, and the FSM state encoding; the responder side uses the same constants.
REQ-030 One sub-module, btn_debounce (5-bit, parameter DEBOUNCE_N, sample-enable input), SHALL implement REQ-019.

Verification (POLL_DIV=8, DEBOUNCE_N=3, behavioural responder model)
REQ-031 switches=0x00A5C3, buttons=0, enable=1 -> every 8 cycles an LED write with wdata=0x0000A5C3; no DIGIT write; press_cnt=0.
REQ-032 button[2] held at 1 for 3 polls -> btn_db_o=5'b00100 after the 3rd poll; exactly one DIGIT write with wdata=1; one press_o pulse.
REQ-033 button[0] toggles 1,0,1,0 across polls (glitch) -> btn_db_o stays 0; no DIGIT write.
REQ-034 buttons 5'b10001 rise together, held for 3 polls -> one event; DIGIT wdata=1.
REQ-035 press_cnt forced to 0xFFFF_FFFF, then a press -> DIGIT wdata=0; press_cnt_o=0.
REQ-036 rst_i asserted in the RD_BTN cycle -> no write in the following cycle; all outputs 0; next poll starts 8 cycles after reset release with enable=1.

Source files
------------

// File: rtl/io_map_pkg.sv
// -----------------------------------------------------------------------------
// io_map_pkg
// Shared IO map for the poll master and the IO responder: the bus addresses of
// the switch, button, LED and seven-segment digit registers, the field widths
// carried on the bus, and the poll FSM state encoding.
// -----------------------------------------------------------------------------
package io_map_pkg;

    localparam logic [31:0] SWITCH_ADDR = 32'hFFFF_F070;
    localparam logic [31:0] BUTTON_ADDR = 32'hFFFF_F078;
    localparam logic [31:0] LED_ADDR    = 32'hFFFF_F060;
    localparam logic [31:0] DIGIT_ADDR  = 32'hFFFF_F000;

    localparam int SW_W  = 24;  // switch bits carried in rdata[23:0]
    localparam int BTN_W = 5;   // button bits carried in rdata[4:0]

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_SW  = 3'd1,
        ST_RD_BTN = 3'd2,
        ST_WR_LED = 3'd3,
        ST_WR_DIG = 3'd4
    } poll_state_e;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Per-bit debouncer for the 5 push buttons. Each bit keeps its last DEBOUNCE_N
// samples; the debounced level moves to the sampled value only when all of
// those samples agree. Samples are taken only on cycles with sample_i=1.
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset (clears history and levels)
//   sample_i  take one sample of btn_i this cycle
//   btn_i     raw button levels
//   btn_db_o  debounced levels
//   rise_o    one-cycle pulse, the cycle after a sample, when any debounced
//             bit went 0->1 on that sample
// DEBOUNCE_N must lie in 2..8.
// -----------------------------------------------------------------------------
module btn_debounce
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_i,
    input  logic [BTN_W-1:0] btn_i,
    output logic [BTN_W-1:0] btn_db_o,
    output logic             rise_o
);

    logic [BTN_W-1:0][DEBOUNCE_N-1:0] hist_q;
    logic [BTN_W-1:0][DEBOUNCE_N-1:0] hist_next;
    logic [BTN_W-1:0]                 db_q;
    logic [BTN_W-1:0]                 db_next;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        hist_next = hist_q;
        db_next   = db_q;
        for (int b = 0; b < BTN_W; b++) begin
            hist_next[b] = {hist_q[b][DEBOUNCE_N-2:0], btn_i[b]};
            if (&hist_next[b]) begin
                db_next[b] = 1'b1;
            end else if (~|hist_next[b]) begin
                db_next[b] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            db_q   <= '0;
            rise_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            if (sample_i) begin
                hist_q <= hist_next;
                db_q   <= db_next;
                // Several bits rising together still make a single event.
                rise_o <= |(db_next & ~db_q);
            end
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/io_poll_master.sv
// -----------------------------------------------------------------------------
// io_poll_master
// Periodically polls the switch and button registers of an IO responder,
// mirrors the switches onto the LEDs, debounces the buttons and, on each
// accepted press, bumps a press counter and writes it to the digit display.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   enable_i      poll enable (an in-flight poll always completes)
//   dram_addr_o   bus address
//   dram_we_o     bus write strobe, one cycle per write
//   dram_wdata_o  bus write data
//   dram_rdata_i  bus read data, combinational for the current address
//   busy_o        FSM is not idle
//   press_o       one-cycle pulse with the digit write of a press event
//   btn_db_o      debounced button levels
//   press_cnt_o   accepted press count
// POLL_DIV (>= 8) is the number of clk_i cycles between poll starts.
// -----------------------------------------------------------------------------
module io_poll_master
    import io_map_pkg::*;
#(
    parameter int POLL_DIV   = 100000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    output logic [31:0]      dram_addr_o,
    output logic             dram_we_o,
    output logic [31:0]      dram_wdata_o,
    input  logic [31:0]      dram_rdata_i,
    output logic             busy_o,
    output logic             press_o,
    output logic [BTN_W-1:0] btn_db_o,
    output logic [31:0]      press_cnt_o
);

    localparam int DIV_W = $clog2(POLL_DIV);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    poll_state_e      state_q;
    logic [SW_W-1:0]  sw_q;
    logic [31:0]      press_cnt_q;
    logic             press_evt;
    logic [7:0]       rdata_unused;

    // Only the switch and button fields of the read data are meaningful.
    assign rdata_unused = dram_rdata_i[31:24];

    // Poll divider: counts while enabled, is held at zero while disabled.
    assign tick = enable_i && (div_q == DIV_W'(POLL_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Samples rdata while the RD_BTN address is on the bus; press_evt is
    // therefore valid during WR_LED.
    btn_debounce #(
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_btn_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sample_i (state_q == ST_RD_BTN),
        .btn_i    (dram_rdata_i[BTN_W-1:0]),
        .btn_db_o (btn_db_o),
        .rise_o   (press_evt)
    );

    // Bus outputs are registered together with the state, so each state's
    // address/strobe/data are presented for exactly the cycle spent there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sw_q         <= '0;
            press_cnt_q  <= '0;
            press_o      <= 1'b0;
            dram_addr_o  <= '0;
            dram_we_o    <= 1'b0;
            dram_wdata_o <= '0;
        end else begin
            press_o      <= 1'b0;
            dram_addr_o  <= '0;
            dram_we_o    <= 1'b0;
            dram_wdata_o <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    // A tick arriving outside IDLE is simply not seen here.
                    if (tick) begin
                        state_q     <= ST_RD_SW;
                        dram_addr_o <= SWITCH_ADDR;
                    end
                end
                ST_RD_SW: begin
                    sw_q        <= dram_rdata_i[SW_W-1:0];
                    state_q     <= ST_RD_BTN;
                    dram_addr_o <= BUTTON_ADDR;
                end
                ST_RD_BTN: begin
                    state_q      <= ST_WR_LED;
                    dram_addr_o  <= LED_ADDR;
                    dram_we_o    <= 1'b1;
                    dram_wdata_o <= {8'h00, sw_q};
                end
                ST_WR_LED: begin
                    if (press_evt) begin
                        state_q      <= ST_WR_DIG;
                        dram_addr_o  <= DIGIT_ADDR;
                        dram_we_o    <= 1'b1;
                        dram_wdata_o <= press_cnt_q + 32'd1;
                        press_cnt_q  <= press_cnt_q + 32'd1;
                        press_o      <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_DIG: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign press_cnt_o = press_cnt_q;

endmodule
